parity_checker: RTL
===================

# parity_checker

Receive-side counterpart of the 16-bit parity generator. Accepts a stream of 16-bit words, each with its parity bit, over a valid/ready handshake and checks each word. Forwards the data with a per-word error flag through one registered stage, and reports per-frame and cumulative error status. Sits at the consumer end of any link whose words were protected by the parity generator.

## Interface
Parameters:
- `ODD`, 0, parity sense: 0 = even (the word's 1s plus the parity bit form an even count, matching the generator's `par_out = ^data_in`); 1 = odd.
- `CW`, 16, width of the cumulative error counter.
- `WCW`, 8, width of the per-frame word counter.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `in_valid`, in, 1, upstream word valid.
- `in_ready`, out, 1, checker can accept.
- `in_data`, in, 16, received word.
- `in_par`, in, 1, received parity bit.
- `in_last`, in, 1, word is last of frame.
- `out_valid`, out, 1, downstream word valid.
- `out_ready`, in, 1, downstream accepts.
- `out_data`, out, 16, forwarded word.
- `out_err`, out, 1, parity error on `out_data`.
- `out_last`, out, 1, forwarded `in_last`.
- `frame_done`, out, 1, one-cycle pulse after a frame's last word is accepted.
- `frame_err`, out, 1, any error in the completed frame; valid with `frame_done`.
- `frame_words`, out, WCW, word count of the completed frame (saturating); valid with `frame_done`.
- `err_count`, out, CW, cumulative parity errors (saturating).
- `clr_cnt`, in, 1, synchronous clear of `err_count`.

## Operation
- Word error: `err = (^in_data) ^ in_par ^ ODD`. Computed combinationally on accept and registered with the data.
- Accept happens when `in_valid && in_ready`.
- Output stage is a single register:
  - `in_ready = (!out_valid || out_ready) && state != REPORT`.
  - On accept, `out_data`, `out_err` and `out_last` load and `out_valid` is set.
  - When `out_valid && out_ready` and there is no accept, `out_valid` clears.
- FSM states:
  - IDLE: no word of the current frame yet. An accept with `in_last = 0` goes to RECV. An accept with `in_last = 1` goes to REPORT.
  - RECV: mid-frame. An accept with `in_last = 1` goes to REPORT. Otherwise stay.
  - REPORT: lasts exactly one cycle. `frame_done = 1` and `in_ready = 0`. Next state is IDLE.
- Frame accumulators:
  - The first accept in IDLE loads `words = 1` and `ferr = err`.
  - Each later accept does `words += 1` (saturating at 2^WCW-1) and `ferr |= err`.
  - `frame_err` and `frame_words` hold the final values during REPORT and keep them until the next REPORT.
- `err_count`:
  - Increments on every accepted word with `err = 1`, saturating at 2^CW-1.
  - `clr_cnt` alone sets it to 0.
  - `clr_cnt` in the same cycle as an erroring accept sets it to 1.
- Reset values: `in_ready` = 1, and every other output = 0. State is IDLE and the accumulators are 0. A reset mid-frame discards the partial frame and any held output word.

## Timing
- Data latency: 1 cycle from accept to `out_valid`.
- Throughput: one word per cycle when `out_ready = 1`. There is exactly one bubble after each frame's last word (the REPORT cycle).
- `frame_done` asserts in the cycle after the accept of the `in_last` word.
- `err_count` updates in the cycle after the erroring accept.
- Backpressure:
  - While `out_valid && !out_ready`, `in_ready` is 0 and all outputs hold stable.
  - `in_data`, `in_par` and `in_last` are sampled only on accept. Their values while `in_valid = 0` are ignored.
- Single-word frame (`in_last` on the first word): takes IDLE → REPORT directly and gives `frame_words = 1`.
- Counter saturation: `err_count` at its maximum stays there on further errors. `frame_words` saturates the same way and the frame still completes normally.

## Structure
- Shared package `parity_pkg`:
  - FSM state enum {IDLE, RECV, REPORT}.
  - `DATA_W = 16`.
  - Parity-function constant shared with the generator.
- Sub-module `parity_calc`: combinational 16-bit reduction XOR plus the `ODD` term. The generator and checker both instantiate it, so their definitions of parity are identical.
- Top level: output register, FSM, frame accumulators, error counter. Estimated at about 150–200 lines.

## Test plan
- Reset, then 8 clean words `0x0000`..`0x0007` with `in_par = ^data`, the last with `in_last = 1`, `out_ready = 1`:
  - Each word appears one cycle later with `out_err = 0`.
  - `frame_done` pulses with `frame_err = 0` and `frame_words = 8`.
  - `err_count = 0`.
- Word `0x0003` with `in_par = 1` (wrong under even parity):
  - `out_err = 1` and `err_count = 1`.
  - The frame's `frame_err = 1`.
  - Repeat with `ODD = 1` and `in_par = 1`: `out_err = 0`.
- Hold `out_ready = 0` for 5 cycles while a word is pending:
  - `in_ready = 0` throughout.
  - `out_data` is stable and no words are lost or duplicated.
- Single-word frame `0x8001` with `in_last = 1`:
  - `frame_done` arrives 1 cycle after accept with `frame_words = 1`.
  - `in_ready = 0` in that cycle.
- Error-counter edge cases:
  - Preload to 0xFFFF using 65535 bad words (or force the counter), then one more error: `err_count` stays 0xFFFF.
  - `clr_cnt` together with an erroring accept: `err_count = 1`.
- Assert `rst_n = 0` mid-frame after 3 words:
  - All outputs return to reset values.
  - The next frame reports `frame_words` counted from 1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/checker pair: data width,
// parity sense constants and the checker's frame FSM states.
package parity_pkg;

    localparam int DATA_W = 16;

    // Parity sense: even means data bits plus parity bit hold an even count of 1s.
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        REPORT
    } state_t;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of one data word; shared by generator and checker so
// both ends agree on exactly the same parity definition.
module parity_calc
    import parity_pkg::*;
#(
    parameter bit ODD = PAR_EVEN
) (
    input  logic [DATA_W-1:0] data,
    output logic              par
);

    assign par = (^data) ^ ODD;

endmodule

// File: rtl/parity_checker.sv
// Receive-side parity checker: one registered output stage carrying a per-word
// error flag, frame-level error reporting and a cumulative error counter.
module parity_checker
    import parity_pkg::*;
#(
    parameter bit ODD = PAR_EVEN,
    parameter int CW  = 16,
    parameter int WCW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              out_last,
    output logic              frame_done,
    output logic              frame_err,
    output logic [WCW-1:0]    frame_words,
    output logic [CW-1:0]     err_count,
    input  logic              clr_cnt
);

    state_t         state;
    logic           accept;
    logic           calc_par;
    logic           word_err;
    logic [WCW-1:0] words;
    logic [WCW-1:0] words_next;
    logic           ferr;
    logic           ferr_next;

    parity_calc #(.ODD(ODD)) u_calc (
        .data (in_data),
        .par  (calc_par)
    );

    assign word_err = calc_par ^ in_par;
    assign in_ready = (!out_valid || out_ready) && (state != REPORT);
    assign accept   = in_valid && in_ready;

    // The first word of a frame restarts the accumulators instead of adding to them.
    always_comb begin
        words_next = words;
        ferr_next  = ferr;
        if (state == IDLE) begin
            words_next = WCW'(1);
            ferr_next  = word_err;
        end else begin
            if (words != {WCW{1'b1}}) begin
                words_next = words + WCW'(1);
            end
            ferr_next = ferr | word_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_err   <= word_err;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Frame results are captured on the last accept so they are valid during REPORT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            words       <= '0;
            ferr        <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            frame_words <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, RECV: begin
                    if (accept) begin
                        words <= words_next;
                        ferr  <= ferr_next;
                        if (in_last) begin
                            state       <= REPORT;
                            frame_done  <= 1'b1;
                            frame_err   <= ferr_next;
                            frame_words <= words_next;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (clr_cnt) begin
            err_count <= (accept && word_err) ? CW'(1) : '0;
        end else if (accept && word_err && (err_count != {CW{1'b1}})) begin
            err_count <= err_count + CW'(1);
        end
    end

endmodule
